// File: rtl/clint_ctrl_if.sv
// Register-bus bundle for clint_ctrl.
//
// Handshake: bus_req is a one-cycle request, sampled on a clk rising edge,
// and there is no backpressure (no ready signal). Every sampled request gets
// exactly one bus_ack pulse on the following cycle. bus_rdata carries read
// data while bus_ack is high and is 0 at all other times, including the ack
// of a write.
//
// Signals:
//   bus_req   : access request, at most one per cycle
//   bus_we    : 1 = write, 0 = read
//   bus_addr  : word offset into the register map
//   bus_wdata : write data
//   bus_ack   : access complete, one cycle after the request
//   bus_rdata : read data, valid while bus_ack is high
interface clint_ctrl_if;
  logic        bus_req;
  logic        bus_we;
  logic [2:0]  bus_addr;
  logic [31:0] bus_wdata;
  logic        bus_ack;
  logic [31:0] bus_rdata;

  modport master (
    output bus_req, bus_we, bus_addr, bus_wdata,
    input  bus_ack, bus_rdata
  );

  modport slave (
    input  bus_req, bus_we, bus_addr, bus_wdata,
    output bus_ack, bus_rdata
  );
endinterface

// File: rtl/clint_ctrl.sv
// Core-local interrupt controller: 64-bit machine timer with compare,
// software-interrupt bit and a prioritised external-interrupt latch, all
// reachable over a word-addressed register bus. Drives the level pending
// lines that feed mip, and takes the handler-done clears from the trap
// controller.
//
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   bus                 : register bus (clint_ctrl_if slave)
//   ext_irq             : asynchronous level external interrupt sources
//   external_int_clear  : handler done, external (clears the claimed source)
//   software_int_clear  : handler done, software
//   timer_int_clear     : handler done, timer (also disarms the compare)
//   meip, mtip, msip    : registered pending outputs
//
// Register map (word offset):
//   0 MSIP  1 MTIMECMP_LO  2 MTIMECMP_HI  3 MTIME_LO  4 MTIME_HI
//   5 EXT_PEND (RO)  6 EXT_EN  7 EXT_CLAIM
module clint_ctrl #(
  parameter int TICK_DIV = 1,
  parameter int EXT_SRC  = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  clint_ctrl_if.slave        bus,
  input  logic [EXT_SRC-1:0] ext_irq,
  input  logic               external_int_clear,
  input  logic               software_int_clear,
  input  logic               timer_int_clear,
  output logic               meip,
  output logic               mtip,
  output logic               msip
);

  localparam logic [7:0] PRESC_MAX = 8'(TICK_DIV - 1);

  logic [7:0]         presc;
  logic [63:0]        mtime;
  logic [63:0]        mtimecmp;
  logic               armed;
  logic [EXT_SRC-1:0] sync1, sync2, sync3;
  logic [EXT_SRC-1:0] pend, en;
  logic [4:0]         claim_r;

  logic               wr, rd, tick;
  logic [EXT_SRC-1:0] ext_rise, clr_mask, pend_en;
  logic [4:0]         claim_id;
  logic [31:0]        rd_mux;

  assign wr       = bus.bus_req & bus.bus_we;
  assign rd       = bus.bus_req & ~bus.bus_we;
  assign tick     = (presc == PRESC_MAX);
  assign ext_rise = sync2 & ~sync3;
  assign pend_en  = pend & en;

  // Lowest enabled pending index wins; ids are index+1 so 0 means none.
  always_comb begin
    claim_id = '0;
    for (int i = EXT_SRC - 1; i >= 0; i--) begin
      if (pend_en[i]) claim_id = 5'(i + 1);
    end
  end

  // Per-bit clear: a claim write naming the id, or handler-done on the
  // claimed id. Ids 0 and > EXT_SRC match no bit and so are ignored.
  always_comb begin
    clr_mask = '0;
    for (int i = 0; i < EXT_SRC; i++) begin
      if (wr && bus.bus_addr == 3'd7 && bus.bus_wdata == 32'(i + 1))
        clr_mask[i] = 1'b1;
      if (external_int_clear && claim_r == 5'(i + 1))
        clr_mask[i] = 1'b1;
    end
  end

  always_comb begin
    rd_mux = '0;
    case (bus.bus_addr)
      3'd0: rd_mux[0] = msip;
      3'd1: rd_mux = mtimecmp[31:0];
      3'd2: rd_mux = mtimecmp[63:32];
      3'd3: rd_mux = mtime[31:0];
      3'd4: rd_mux = mtime[63:32];
      3'd5: rd_mux[EXT_SRC-1:0] = pend;
      3'd6: rd_mux[EXT_SRC-1:0] = en;
      default: rd_mux[4:0] = claim_id;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.bus_ack   <= 1'b0;
      bus.bus_rdata <= '0;
      presc         <= '0;
      mtime         <= '0;
      mtimecmp      <= '1;
      armed         <= 1'b0;
      mtip          <= 1'b0;
      msip          <= 1'b0;
      sync1         <= '0;
      sync2         <= '0;
      sync3         <= '0;
      pend          <= '0;
      en            <= '0;
      claim_r       <= '0;
      meip          <= 1'b0;
    end else begin
      // Bus response: reads see register values from before this edge.
      bus.bus_ack   <= bus.bus_req;
      bus.bus_rdata <= rd ? rd_mux : '0;

      // Timer: the prescaler free-runs; a bus write to a mtime half takes
      // that cycle's increment away.
      presc <= tick ? '0 : presc + 8'd1;
      if (wr && bus.bus_addr == 3'd3)      mtime[31:0]  <= bus.bus_wdata;
      else if (wr && bus.bus_addr == 3'd4) mtime[63:32] <= bus.bus_wdata;
      else if (tick)                       mtime        <= mtime + 64'd1;

      if (wr && bus.bus_addr == 3'd1) mtimecmp[31:0]  <= bus.bus_wdata;
      if (wr && bus.bus_addr == 3'd2) mtimecmp[63:32] <= bus.bus_wdata;

      if (timer_int_clear)                                  armed <= 1'b0;
      else if (wr && (bus.bus_addr == 3'd1 || bus.bus_addr == 3'd2)) armed <= 1'b1;

      mtip <= timer_int_clear ? 1'b0 : (armed && (mtime >= mtimecmp));

      // Software interrupt: the clear beats a simultaneous write.
      if (software_int_clear)              msip <= 1'b0;
      else if (wr && bus.bus_addr == 3'd0) msip <= bus.bus_wdata[0];

      // External: 2-flop synchronizer plus a history flop for edge detect.
      sync1 <= ext_irq;
      sync2 <= sync1;
      sync3 <= sync2;
      pend  <= (pend & ~clr_mask) | ext_rise;
      if (wr && bus.bus_addr == 3'd6) en <= bus.bus_wdata[EXT_SRC-1:0];

      // A new claim read in the same cycle as a handler-done keeps the
      // newer claim.
      if (external_int_clear && claim_r != 5'd0) claim_r <= '0;
      if (rd && bus.bus_addr == 3'd7 && claim_id != 5'd0) claim_r <= claim_id;

      meip <= external_int_clear ? 1'b0 : |pend_en;
    end
  end

endmodule
